// File: rtl/mt_pkg.sv
// Shared types and constants for the Mersenne-Twister request scheduler.
package mt_pkg;

  typedef enum logic [2:0] {
    GRST  = 3'd0,
    WAIT  = 3'd1,
    ARB   = 3'd2,
    FETCH = 3'd3,
    GAPW  = 3'd4
  } mt_sched_state_t;

  localparam int          MT_WORD_W       = 32;
  localparam logic [31:0] MT_DEFAULT_SEED = 32'd5489;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after the pointer, wrapping from NREQ-1 back to 0.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] k_s;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k_s       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k_s = IDX_W'((int'(ptr) + i) % NREQ);
      if (!any && req[k_s]) begin
        grant[k_s] = 1'b1;
        grant_idx  = k_s;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mt_sched.sv
// Shares one MT19937 generator between NREQ requesters: reset/seed sequencing,
// paced trig pulses and round-robin delivery. Macro MT_SCHED_STATS_EN adds served_cnt.
module mt_sched
  import mt_pkg::*;
#(
  parameter int                    NREQ    = 4,
  parameter logic [MT_WORD_W-1:0]  SEED    = MT_DEFAULT_SEED,
  parameter int                    GAP     = 2,
  parameter int                    RST_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [MT_WORD_W-1:0] rsp_data,
  input  logic                 reseed_req,
  input  logic [MT_WORD_W-1:0] reseed_val,
  output logic                 reseed_ack,
  output logic                 busy,
  output logic                 gen_rst,
  output logic [MT_WORD_W-1:0] gen_seed,
  output logic                 gen_trig,
  input  logic [MT_WORD_W-1:0] gen_num,
  input  logic                 gen_ready,
  output logic [31:0]          served_cnt
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  mt_sched_state_t      state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [NREQ-1:0]      grant_oh_q, grant_oh_d;
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [MT_WORD_W-1:0] rsp_data_q, rsp_data_d;
  logic                 reseed_ack_q, reseed_ack_d;
  logic                 busy_q, busy_d;
  logic                 gen_rst_q, gen_rst_d;
  logic [MT_WORD_W-1:0] gen_seed_q, gen_seed_d;
  logic                 gen_trig_q, gen_trig_d;

  logic [NREQ-1:0]      arb_oh_s;
  logic [IDX_W-1:0]     arb_idx_s;
  logic                 arb_any_s;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (arb_oh_s),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    grant_oh_d   = grant_oh_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    reseed_ack_d = 1'b0;
    gen_rst_d    = gen_rst_q;
    gen_seed_d   = gen_seed_q;
    gen_trig_d   = 1'b0;
    case (state_q)
      GRST: begin
        if (cnt_q >= 16'(RST_CYC - 1)) begin
          gen_rst_d = 1'b0;
          cnt_d     = 16'd0;
          state_d   = WAIT;
        end else begin
          gen_rst_d = 1'b1;
          cnt_d     = cnt_q + 16'd1;
        end
      end
      WAIT: begin
        if (gen_ready) begin
          state_d = ARB;
        end else begin
          state_d = WAIT;
        end
      end
      ARB: begin
        // Reseed outranks pending requests; their req bits stay up and are served after reinit.
        if (reseed_req) begin
          reseed_ack_d = 1'b1;
          gen_seed_d   = reseed_val;
          gen_rst_d    = 1'b1;
          cnt_d        = 16'd0;
          state_d      = GRST;
        end else if (!gen_ready) begin
          state_d = WAIT;
        end else if (arb_any_s) begin
          grant_oh_d  = arb_oh_s;
          grant_idx_d = arb_idx_s;
          state_d     = FETCH;
        end else begin
          state_d = ARB;
        end
      end
      FETCH: begin
        // The word is taken now; the trig that advances the generator follows one cycle later.
        if (gen_ready) begin
          gen_trig_d  = 1'b1;
          rsp_data_d  = gen_num;
          rsp_valid_d = grant_oh_q;
          rr_ptr_d    = (grant_idx_q == IDX_W'(NREQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
          cnt_d       = 16'd0;
          state_d     = GAPW;
        end else begin
          grant_oh_d = '0;
          state_d    = WAIT;
        end
      end
      GAPW: begin
        if (cnt_q >= 16'(GAP - 1)) begin
          cnt_d   = 16'd0;
          state_d = ARB;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: begin
        gen_rst_d = 1'b1;
        cnt_d     = 16'd0;
        state_d   = GRST;
      end
    endcase
    busy_d = (state_d != ARB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= GRST;
      cnt_q        <= 16'd0;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      grant_oh_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      reseed_ack_q <= 1'b0;
      busy_q       <= 1'b1;
      gen_rst_q    <= 1'b1;
      gen_seed_q   <= SEED;
      gen_trig_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      grant_oh_q   <= grant_oh_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      reseed_ack_q <= reseed_ack_d;
      busy_q       <= busy_d;
      gen_rst_q    <= gen_rst_d;
      gen_seed_q   <= gen_seed_d;
      gen_trig_q   <= gen_trig_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign reseed_ack = reseed_ack_q;
  assign busy       = busy_q;
  assign gen_rst    = gen_rst_q;
  assign gen_seed   = gen_seed_q;
  assign gen_trig   = gen_trig_q;

`ifdef MT_SCHED_STATS_EN
  logic [31:0] served_q, served_d;

  // Counts in step with the rsp_valid pulse; saturates rather than wrapping.
  always_comb begin
    served_d = served_q;
    if ((|rsp_valid_d) && (served_q != 32'hFFFF_FFFF)) begin
      served_d = served_q + 32'd1;
    end else begin
      served_d = served_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q <= 32'd0;
    end else begin
      served_q <= served_d;
    end
  end

  assign served_cnt = served_q;
`else
  assign served_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mt_sched.sv
// Directed bench for mt_sched with a behavioural MT19937 generator that drops
// gen_ready during init and every 624-word regeneration.
module tb_mt_sched;

  localparam int NREQ      = 4;
  localparam int REF_N     = 700;
  localparam int INIT_CYC  = 10;
  localparam int REGEN_CYC = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req = 4'b0;
  logic            reseed_req = 1'b0;
  logic [31:0]     reseed_val = 32'd0;
  logic [3:0]      rsp_valid;
  logic [31:0]     rsp_data;
  logic            reseed_ack;
  logic            busy;
  logic            gen_rst;
  logic [31:0]     gen_seed;
  logic            gen_trig;
  logic [31:0]     gen_num;
  logic            gen_ready = 1'b0;
  logic [31:0]     served_cnt;

  bit [31:0] ref0 [REF_N];
  bit [31:0] ref1 [REF_N];
  bit [31:0] got  [REF_N];
  int        wcnt = 0;
  int        g_busy = 0;
  bit        use_s1 = 1'b0;
  int        n_checks = 0;
  int        n_errors = 0;

  always #5 clk = ~clk;

  mt_sched #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .reseed_req (reseed_req),
    .reseed_val (reseed_val),
    .reseed_ack (reseed_ack),
    .busy       (busy),
    .gen_rst    (gen_rst),
    .gen_seed   (gen_seed),
    .gen_trig   (gen_trig),
    .gen_num    (gen_num),
    .gen_ready  (gen_ready),
    .served_cnt (served_cnt)
  );

  function automatic bit [31:0] temper(input bit [31:0] x);
    bit [31:0] y;
    y = x;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9d2c_5680);
    y = y ^ ((y << 15) & 32'hefc6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  task automatic gen_seq(input bit [31:0] seed, input bit sel);
    bit [31:0] a [624];
    bit [31:0] y;
    bit [31:0] v;
    a[0] = seed;
    for (int i = 1; i < 624; i++) a[i] = 32'd1812433253 * (a[i-1] ^ (a[i-1] >> 30)) + 32'(i);
    for (int k = 0; k < REF_N; k++) begin
      if (k % 624 == 0) begin
        for (int i = 0; i < 624; i++) begin
          y = (a[i] & 32'h8000_0000) | (a[(i + 1) % 624] & 32'h7fff_ffff);
          v = a[(i + 397) % 624] ^ (y >> 1);
          if (y[0]) v = v ^ 32'h9908_b0df;
          a[i] = v;
        end
      end
      if (sel) ref1[k] = temper(a[k % 624]);
      else ref0[k] = temper(a[k % 624]);
    end
  endtask

  // Generator stand-in: word stream from the reference tables, ready low while busy.
  always @(posedge clk) begin
    if (gen_rst === 1'b1) begin
      gen_ready <= 1'b0;
      g_busy    <= INIT_CYC;
      wcnt      <= 0;
      use_s1    <= (gen_seed == 32'd1);
    end else if (g_busy != 0) begin
      g_busy <= g_busy - 1;
      if (g_busy == 1) gen_ready <= 1'b1;
    end else if (gen_trig === 1'b1 && gen_ready) begin
      wcnt <= wcnt + 1;
      if ((wcnt + 1) % 624 == 0) begin
        gen_ready <= 1'b0;
        g_busy    <= REGEN_CYC;
      end
    end
  end

  assign gen_num = (wcnt < REF_N) ? (use_s1 ? ref1[wcnt] : ref0[wcnt]) : 32'd0;

  task automatic do_reset();
    req = 4'b0;
    reseed_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int max_cyc, output logic [3:0] v, output logic [31:0] d,
                          output int cyc, output bit ok);
    ok = 1'b0; cyc = 0; v = 4'b0; d = 32'd0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid !== 4'b0) begin
        v = rsp_valid; d = rsp_data; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n_hi;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0) begin n_errors++; $display("FAIL reset_rsp_valid got %h want %h", rsp_valid, 4'b0); end
    n_checks++; if (rsp_data !== 32'd0) begin n_errors++; $display("FAIL reset_rsp_data got %h want %h", rsp_data, 32'd0); end
    n_checks++; if (reseed_ack !== 1'b0 || gen_trig !== 1'b0) begin n_errors++; $display("FAIL reset_ack_trig got %b%b want 00", reseed_ack, gen_trig); end
    n_checks++; if (gen_rst !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL reset_rst_busy got %b%b want 11", gen_rst, busy); end
    n_checks++; if (gen_seed !== 32'd5489) begin n_errors++; $display("FAIL reset_seed got %0d want 5489", gen_seed); end
    n_checks++; if (served_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_served got %0d want 0", served_cnt); end
    rst_n = 1'b1;
    n_hi = 0;
    for (int i = 0; i < 10 && gen_rst === 1'b1; i++) begin
      n_hi++;
      @(negedge clk);
    end
    n_checks++; if (n_hi != 2) begin n_errors++; $display("FAIL reset_gen_rst_len got %0d want 2", n_hi); end
  endtask

  task automatic test_first_words();
    bit ok; int cyc; logic [3:0] v; logic [31:0] d;
    for (int i = 0; i < 200 && gen_ready !== 1'b1; i++) @(negedge clk);
    req = 4'b0001;
    wait_rsp(100, v, d, cyc, ok);
    n_checks++; if (!ok || v !== 4'b0001) begin n_errors++; $display("FAIL first_valid got %b want 0001 (ok=%0d)", v, ok); end
    n_checks++; if (d !== 32'd3499211612) begin n_errors++; $display("FAIL first_data got %0d want 3499211612", d); end
    wait_rsp(100, v, d, cyc, ok);
    req = 4'b0;
    n_checks++; if (!ok || v !== 4'b0001) begin n_errors++; $display("FAIL second_valid got %b want 0001 (ok=%0d)", v, ok); end
    n_checks++; if (d !== 32'd581869302) begin n_errors++; $display("FAIL second_data got %0d want 581869302", d); end
    n_checks++; if (cyc != 4) begin n_errors++; $display("FAIL second_spacing got %0d want 4", cyc); end
  endtask

  task automatic test_idle_latency();
    bit ok;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL latency_idle_timeout got busy=%b want 0", busy); end
    req = 4'b0100;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0) begin n_errors++; $display("FAIL latency_t1 got %b want 0000", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0100 || gen_trig !== 1'b1) begin n_errors++; $display("FAIL latency_t2 got %b trig %b want 0100 trig 1", rsp_valid, gen_trig); end
    n_checks++; if (rsp_data !== 32'd3890346734) begin n_errors++; $display("FAIL latency_data got %0d want 3890346734", rsp_data); end
    req = 4'b0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0) begin n_errors++; $display("FAIL latency_pulse_width got %b want 0000", rsp_valid); end
  endtask

  task automatic test_round_robin();
    bit ok; int cyc; logic [3:0] v; logic [31:0] d; logic [3:0] exp_v;
    do_reset();
    wait_idle(ok);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(100, v, d, cyc, ok);
      exp_v = 4'b0001 << (k % 4);
      n_checks++; if (!ok || v !== exp_v) begin n_errors++; $display("FAIL rr_grant%0d got %b want %b", k, v, exp_v); end
      n_checks++; if (d !== ref0[k]) begin n_errors++; $display("FAIL rr_data%0d got %0d want %0d", k, d, ref0[k]); end
    end
    req = 4'b0;
  endtask

  task automatic test_reseed();
    bit ok; int cyc; int n_hi; logic [3:0] v; logic [31:0] d;
    do_reset();
    wait_idle(ok);
    reseed_val = 32'd1;
    reseed_req = 1'b1;
    req = 4'b0010;
    @(negedge clk);
    n_checks++; if (reseed_ack !== 1'b1 || rsp_valid !== 4'b0) begin n_errors++; $display("FAIL reseed_ack got %b valid %b want 1 0000", reseed_ack, rsp_valid); end
    n_checks++; if (gen_rst !== 1'b1 || gen_seed !== 32'd1) begin n_errors++; $display("FAIL reseed_gen got rst %b seed %0d want 1 1", gen_rst, gen_seed); end
    reseed_req = 1'b0;
    n_hi = 1;
    @(negedge clk);
    n_checks++; if (reseed_ack !== 1'b0) begin n_errors++; $display("FAIL reseed_ack_width got %b want 0", reseed_ack); end
    for (int i = 0; i < 10 && gen_rst === 1'b1; i++) begin
      n_hi++;
      @(negedge clk);
    end
    n_checks++; if (n_hi != 2) begin n_errors++; $display("FAIL reseed_rst_len got %0d want 2", n_hi); end
    wait_rsp(200, v, d, cyc, ok);
    n_checks++; if (!ok || v !== 4'b0010) begin n_errors++; $display("FAIL reseed_valid got %b want 0010", v); end
    n_checks++; if (d !== 32'd1791095845) begin n_errors++; $display("FAIL reseed_data got %0d want 1791095845", d); end
    req = 4'b0;
  endtask

  task automatic test_regen();
    bit ok; int cyc; logic [3:0] v; logic [31:0] d;
    do_reset();
    wait_idle(ok);
    req = 4'b0100;
    for (int k = 0; k < REF_N; k++) begin
      wait_rsp(100, v, d, cyc, ok);
      got[k] = d;
      n_checks++;
      if (!ok || v !== 4'b0100 || d !== ref0[k]) begin
        n_errors++;
        $display("FAIL regen_word%0d got %b/%0d want 0100/%0d", k, v, d, ref0[k]);
        break;
      end
    end
    req = 4'b0;
    n_checks++; if (got[624] !== ref0[624]) begin n_errors++; $display("FAIL regen_word625 got %0d want %0d", got[624], ref0[624]); end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok; int cyc; logic [3:0] v; logic [31:0] d;
    do_reset();
    wait_idle(ok);
    req = 4'b0001;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 4'b0 || gen_rst !== 1'b1) begin n_errors++; $display("FAIL midrst_now got %b rst %b want 0000 1", rsp_valid, gen_rst); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0 || rsp_data !== 32'd0) begin n_errors++; $display("FAIL midrst_lost got %b/%0d want 0000/0", rsp_valid, rsp_data); end
    rst_n = 1'b1;
    wait_rsp(200, v, d, cyc, ok);
    n_checks++; if (!ok || v !== 4'b0001 || d !== 32'd3499211612) begin n_errors++; $display("FAIL midrst_restart got %b/%0d want 0001/3499211612", v, d); end
    req = 4'b0;
  endtask

  task automatic test_stats();
    bit ok; int cyc; logic [3:0] v; logic [31:0] d; logic [31:0] exp_served;
`ifdef MT_SCHED_STATS_EN
    exp_served = 32'd10;
`else
    exp_served = 32'd0;
`endif
    do_reset();
    wait_idle(ok);
    req = 4'b0001;
    for (int k = 0; k < 10; k++) wait_rsp(100, v, d, cyc, ok);
    req = 4'b0;
    n_checks++; if (d !== ref0[9]) begin n_errors++; $display("FAIL stats_last_word got %0d want %0d", d, ref0[9]); end
    repeat (4) @(negedge clk);
    n_checks++; if (served_cnt !== exp_served) begin n_errors++; $display("FAIL stats_served got %0d want %0d", served_cnt, exp_served); end
  endtask

  initial begin
    gen_seq(32'd5489, 1'b0);
    gen_seq(32'd1, 1'b1);
    test_reset();
    test_first_words();
    test_idle_latency();
    test_round_robin();
    test_reseed();
    test_regen();
    test_reset_mid_fetch();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mt_sched.md
Name: mt_sched

Overview:
- Scheduler sharing one Mersenne-Twister generator between NREQ requesters.
- Sequences the generator's synchronous reset and seeding, and waits out its init and regeneration phases (gen_ready low).
- Issues single-cycle trig pulses, spaced so the generator's synchronous SRAM read has settled.
- Grants requesters round-robin and returns each 32-bit word with a per-requester valid pulse.
- Sits between the generator instance and consumer blocks.

Parameters:
- NREQ, 4, number of requesters (2..16)
- SEED, 5489, seed driven after async reset
- GAP, 2, idle cycles after each trig before the next arbitration (>=2)
- RST_CYC, 2, cycles gen_rst is held high

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  level request per requester; held until its rsp_valid bit
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: rsp_data belongs to that requester
- rsp_data  out  32  random word, registered
- reseed_req  in  1  level request to reseed
- reseed_val  in  32  new seed, sampled when reseed_ack pulses
- reseed_ack  out  1  one-cycle pulse: reseed accepted
- busy  out  1  high whenever state != ARB
- gen_rst  out  1  to generator rst (synchronous, active-high)
- gen_seed  out  32  to generator seed
- gen_trig  out  1  to generator trig
- gen_num  in  32  generator r_num (combinational from its SRAM output)
- gen_ready  in  1  generator ready (extraction phase)
- served_cnt  out  32  words delivered (see Optional Feature)

Behaviour:
- Async reset, all outputs registered:
  - rsp_valid=0, rsp_data=0, reseed_ack=0, gen_trig=0, served_cnt=0.
  - gen_rst=1, gen_seed=SEED, busy=1.
  - State = GRST, RR pointer = 0.
- States: GRST, WAIT, ARB, FETCH, GAPW.
- GRST: hold gen_rst=1 for RST_CYC cycles, then gen_rst=0 and go to WAIT.
- WAIT: stay until gen_ready=1, then go to ARB.
- ARB, in priority order:
  1. reseed_req=1: pulse reseed_ack, latch gen_seed<=reseed_val, go to GRST. Reseed has priority over pending req; pending req bits are kept and served after reinit.
  2. Else gen_ready=0: go to WAIT.
  3. Else any req: register grant = first set bit at or after the RR pointer (rr_arbiter), go to FETCH.
  4. Else stay.
- FETCH, one cycle:
  - If gen_ready=1: gen_trig=1, capture rsp_data<=gen_num, rsp_valid[grant]<=1 next cycle, RR pointer<=grant+1 mod NREQ, go to GAPW.
  - If gen_ready=0: no trig, no response, grant dropped, go to WAIT. The requester stays pending.
- GAPW: count GAP cycles, then go to ARB.
- Throughput and latency:
  - Throughput is one word per GAP+2 cycles.
  - Idle latency: req high in cycle t (state ARB, gen_ready=1) gives rsp_valid in cycle t+2.
- Requester rules:
  - A requester must drop req the cycle after its rsp_valid or it is re-queued.
  - req changes during FETCH/GAPW are ignored until the next ARB.
- Simultaneous events:
  - reseed_req and req in the same ARB cycle: reseed wins.
  - Exactly one rsp_valid bit is high per response.
- Wrap: RR pointer wraps NREQ-1 to 0. A lone requester is re-granted every slot.
- Reset mid-operation: rst_n low in any state aborts immediately to GRST values. An in-flight response is lost and a rsp_valid pulse is never extended.

Optional Feature:
- Macro MT_SCHED_STATS_EN.
- Defined: served_cnt increments on every rsp_valid pulse, saturates at 32'hFFFFFFFF, and clears only on rst_n.
- Undefined: served_cnt tied to 0 and no counter logic is generated.

Decomposition:
- Package mt_pkg:
  - state enum mt_sched_state_t {GRST, WAIT, ARB, FETCH, GAPW}
  - MT_WORD_W=32
  - MT_DEFAULT_SEED=5489
- Sub-module rr_arbiter:
  - Parameterised by NREQ.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational.

Test Plan:
- Reset, SEED=5489, real generator, req[0] held after gen_ready rises -> first rsp_data=3499211612 and second=581869302, both with rsp_valid=4'b0001, spaced GAP+2=4 cycles.
- req=4'b1111 held, pointer 0 -> grant order 0,1,2,3,0 and consecutive rsp_data equal the MT19937 sequence in order.
- Draw 700 words through req[2] -> no stale or duplicate words across the regeneration gap (gen_ready low), and word 625 equals the reference model's value.
- reseed_req with reseed_val=1 in the same cycle as req[1] -> reseed_ack pulses first, gen_rst high RST_CYC cycles, then req[1] receives 1791095845.
- rst_n pulsed low during FETCH -> rsp_valid stays 0, gen_rst=1 next edge, and the sequence restarts at 3499211612.
- With MT_SCHED_STATS_EN defined, 10 served words -> served_cnt=10; without the macro, served_cnt=0.
